// File: rtl/vx_ahb_pkg.sv
// Shared types and sizing helpers for the VX-to-AHB memory arbiter.
package vx_ahb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Default configuration and the widths derived from it.
  localparam int NUM_REQS_DEFAULT       = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 64;
  localparam int IDX_WIDTH              = $clog2(NUM_REQS_DEFAULT);
  localparam int WDOG_WIDTH             = $clog2(TIMEOUT_CYCLES_DEFAULT);

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a watchdog that must hold values up to t-1.
  function automatic int wdog_width(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module vx_rr_arbiter
  import vx_ahb_pkg::*;
#(
  parameter  int NUM_REQS = NUM_REQS_DEFAULT,
  localparam int IDX_W    = idx_width(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                any_valid
);

  logic [IDX_W:0]   cand_sum [NUM_REQS];
  logic [IDX_W-1:0] cand_idx [NUM_REQS];

  // Candidate index for each offset from the pointer, wrapped into 0..NUM_REQS-1.
  generate
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= (IDX_W+1)'(NUM_REQS))
                          ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(NUM_REQS))
                          : cand_sum[gi][IDX_W-1:0];
    end
  endgenerate

  // Walk offsets from farthest to nearest so the nearest valid candidate wins.
  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      if (valid[cand_idx[k]]) begin
        grant_idx = cand_idx[k];
        any_valid = 1'b1;
      end
    end
    grant = '0;
    if (any_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/vx_ahb_mem_arbiter.sv
// Shares one blocking VX-to-AHB adapter between several requesters, one transaction
// in flight, with a watchdog that turns a dropped transaction into an error response.
module vx_ahb_mem_arbiter
  import vx_ahb_pkg::*;
#(
  parameter int NUM_REQS       = 4,
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            up_req_valid,
  input  logic [NUM_REQS-1:0]            up_req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] up_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] up_req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  up_req_tag,
  output logic [NUM_REQS-1:0]            up_req_ready,
  output logic [NUM_REQS-1:0]            up_rsp_valid,
  output logic [DATA_WIDTH-1:0]          up_rsp_data,
  output logic [TAG_WIDTH-1:0]           up_rsp_tag,
  output logic                           up_rsp_err,
  input  logic [NUM_REQS-1:0]            up_rsp_ready,
  output logic                           mem_req_valid,
  output logic                           mem_req_rw,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr,
  output logic [DATA_WIDTH-1:0]          mem_req_data,
  input  logic                           mem_req_ready,
  input  logic                           mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          mem_rsp_data,
  output logic                           mem_rsp_ready,
  output logic                           timeout_pulse
);

  localparam int                IDX_W     = idx_width(NUM_REQS);
  localparam int                WDOG_W    = wdog_width(TIMEOUT_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQS - 1);

  arb_state_e             state_reg;
  logic [IDX_W-1:0]       rr_ptr_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic                   rw_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [DATA_WIDTH-1:0]  data_reg;
  logic [TAG_WIDTH-1:0]   tag_reg;
  logic [DATA_WIDTH-1:0]  rsp_data_reg;
  logic                   rsp_err_reg;
  logic [WDOG_W-1:0]      wdog_reg;

  logic [ADDR_WIDTH-1:0]  req_addr_arr [NUM_REQS];
  logic [DATA_WIDTH-1:0]  req_data_arr [NUM_REQS];
  logic [TAG_WIDTH-1:0]   req_tag_arr  [NUM_REQS];

  logic [NUM_REQS-1:0]    grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   any_valid;
  logic                   wdog_expired;

  // Unpack the flat request buses and decode the one-hot response valid.
  generate
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_lane
      assign req_addr_arr[gi] = up_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_data_arr[gi] = up_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_tag_arr[gi]  = up_req_tag[gi*TAG_WIDTH +: TAG_WIDTH];
      assign up_rsp_valid[gi] = (state_reg == RESP) && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  vx_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_rr_arbiter (
    .valid     (up_req_valid),
    .rr_ptr    (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Grants are offered only while idle; reset masks them so every output reads 0.
  assign up_req_ready  = ((state_reg == IDLE) && !reset) ? grant : '0;
  assign mem_req_valid = (state_reg == ISSUE);
  assign mem_req_rw    = rw_reg;
  assign mem_req_addr  = addr_reg;
  assign mem_req_data  = data_reg;
  assign mem_rsp_ready = (state_reg == WAIT);
  assign up_rsp_data   = rsp_data_reg;
  assign up_rsp_tag    = tag_reg;
  assign up_rsp_err    = rsp_err_reg;

  // A response arriving in the last watchdog cycle takes priority over the timeout.
  assign wdog_expired  = (state_reg == WAIT) && !mem_rsp_valid && (wdog_reg == WDOG_LAST);
  assign timeout_pulse = wdog_expired;

  // Arbitration FSM: capture winner, issue to adapter, wait (with watchdog), respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      idx_reg      <= '0;
      rw_reg       <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      tag_reg      <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
      wdog_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            idx_reg    <= grant_idx;
            rw_reg     <= up_req_rw[grant_idx];
            addr_reg   <= req_addr_arr[grant_idx];
            data_reg   <= req_data_arr[grant_idx];
            tag_reg    <= req_tag_arr[grant_idx];
            rr_ptr_reg <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            wdog_reg  <= '0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (!rw_reg) begin
              rsp_data_reg <= mem_rsp_data;
              rsp_err_reg  <= 1'b0;
              state_reg    <= RESP;
            end else begin
              // Write acks are consumed here; requesters never see them.
              state_reg <= IDLE;
            end
          end else if (wdog_expired) begin
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b1;
            state_reg    <= RESP;
          end else begin
            wdog_reg <= wdog_reg + WDOG_W'(1);
          end
        end
        RESP: begin
          if (up_rsp_ready[idx_reg]) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_ahb_mem_arbiter.sv
// Transaction-level bench: requesters and a configurable memory are driven each cycle,
// and a phase-based reference model predicts grants, adapter traffic and responses.
module tb_vx_ahb_mem_arbiter;

  localparam int N  = 4;
  localparam int DW = 512;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    up_req_valid = '0;
  logic [N-1:0]    up_req_rw = '0;
  logic [N*AW-1:0] up_req_addr = '0;
  logic [N*DW-1:0] up_req_data = '0;
  logic [N*TW-1:0] up_req_tag = '0;
  logic [N-1:0]    up_req_ready;
  logic [N-1:0]    up_rsp_valid;
  logic [DW-1:0]   up_rsp_data;
  logic [TW-1:0]   up_rsp_tag;
  logic            up_rsp_err;
  logic [N-1:0]    up_rsp_ready = '0;
  logic            mem_req_valid;
  logic            mem_req_rw;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic            mem_req_ready = 1'b0;
  logic            mem_rsp_valid = 1'b0;
  logic [DW-1:0]   mem_rsp_data = '0;
  logic            mem_rsp_ready;
  logic            timeout_pulse;

  always #5 clk = ~clk;

  vx_ahb_mem_arbiter #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .up_req_valid(up_req_valid), .up_req_rw(up_req_rw), .up_req_addr(up_req_addr),
    .up_req_data(up_req_data), .up_req_tag(up_req_tag), .up_req_ready(up_req_ready),
    .up_rsp_valid(up_rsp_valid), .up_rsp_data(up_rsp_data), .up_rsp_tag(up_rsp_tag),
    .up_rsp_err(up_rsp_err), .up_rsp_ready(up_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_ready(mem_rsp_ready), .timeout_pulse(timeout_pulse)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Requester side: one pending request per requester.
  bit            pend   [N];
  bit            p_rw   [N];
  logic [AW-1:0] p_addr [N];
  logic [TW-1:0] p_tag  [N];
  logic [DW-1:0] p_data [N];

  // Transaction phase: 0 none, 1 awaiting adapter accept, 2 awaiting adapter response,
  // 3 awaiting upstream response consumption.
  int            rr = 0, phase = 0, age = 0, cur_idx = 0;
  bit            cur_rw;
  logic [AW-1:0] cur_addr;
  logic [TW-1:0] cur_tag;
  logic [DW-1:0] cur_data, exp_rsp_data;
  bit            exp_err;
  int            stall_left = 0, rsp_delay = 0, up_stall_left = 0;
  int            knob_req_stall = 0, knob_rsp_delay = 1, knob_up_stall = 0;
  bit            knob_random = 0, refill = 0, fixed_data = 0;
  int            txn_no = 0, obs_rsp_cnt = 0, obs_to_cnt = 0;
  int            grant_log [$];

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int k = 0; k < DW/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic new_req(input int i, input bit rw, input logic [AW-1:0] a,
                         input logic [TW-1:0] t, input logic [DW-1:0] d);
    pend[i] = 1'b1; p_rw[i] = rw; p_addr[i] = a; p_tag[i] = t; p_data[i] = d;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      up_req_valid[i]           = pend[i];
      up_req_rw[i]              = p_rw[i];
      up_req_addr[i*AW +: AW]   = p_addr[i];
      up_req_tag[i*TW +: TW]    = p_tag[i];
      up_req_data[i*DW +: DW]   = p_data[i];
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_reqs();
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    #1;
    check("reset_ctrl", {up_req_ready, up_rsp_valid, mem_req_valid, mem_rsp_ready,
                         timeout_pulse, up_rsp_err, mem_req_rw}, '0);
    check("reset_addr_tag", {mem_req_addr, up_rsp_tag}, '0);
    check("reset_req_data", mem_req_data, '0);
    check("reset_rsp_data", up_rsp_data, '0);
    phase = 0; rr = 0; age = 0;
    grant_log.delete();
    repeat (2) @(negedge clk);
    up_req_valid  = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    up_rsp_ready  = '0;
    reset = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, advance the model.
  task automatic step();
    logic [N-1:0] exp_ready, exp_rv;
    int g, r;
    @(negedge clk);
    if (phase == 2) age++;
    if (knob_random) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 3) == 0)
          new_req(i, 1'($urandom), AW'($urandom), TW'($urandom), rand_line());
      end
    end
    if (refill)
      for (int i = 0; i < N; i++)
        if (!pend[i]) new_req(i, 1'b0, AW'($urandom), TW'($urandom), rand_line());
    drive_reqs();
    mem_req_ready = (phase == 1) ? (stall_left == 0) : (knob_random ? 1'($urandom) : 1'b0);
    if (phase == 2) mem_rsp_valid = (rsp_delay >= 0) && (age >= rsp_delay);
    else            mem_rsp_valid = knob_random ? 1'($urandom) : 1'b0;
    mem_rsp_data = fixed_data ? {64{8'hA5}} : rand_line();
    up_rsp_ready = knob_random ? N'($urandom) : '0;
    if (phase == 3) up_rsp_ready[cur_idx] = (up_stall_left == 0);
    #1;

    for (int k = 0; k < N; k++)
      if (up_req_ready[k]) begin grant_log.push_back(k); break; end
    if (timeout_pulse) obs_to_cnt++;
    if ((up_rsp_valid & up_rsp_ready) != '0) obs_rsp_cnt++;

    exp_ready = '0;
    g = -1;
    if (phase == 0)
      for (int k = 0; k < N; k++) begin
        if (pend[(rr + k) % N]) begin g = (rr + k) % N; exp_ready[g] = 1'b1; break; end
      end
    exp_rv = '0;
    if (phase == 3) exp_rv[cur_idx] = 1'b1;
    check("req_ready", up_req_ready, exp_ready);
    check("mem_req_valid", mem_req_valid, phase == 1);
    check("mem_rsp_ready", mem_rsp_ready, phase == 2);
    check("up_rsp_valid", up_rsp_valid, exp_rv);

    case (phase)
      0: begin
        check("timeout_pulse", timeout_pulse, 1'b0);
        if (g >= 0) begin
          cur_idx = g; cur_rw = p_rw[g]; cur_addr = p_addr[g];
          cur_tag = p_tag[g]; cur_data = p_data[g];
          pend[g] = 1'b0;
          rr = (g + 1) % N;
          phase = 1;
          if (knob_random) begin
            stall_left    = $urandom_range(0, 3);
            r             = $urandom_range(0, 9);
            rsp_delay     = (r == 0) ? -1 : (r == 1) ? TO : $urandom_range(1, 12);
            up_stall_left = $urandom_range(0, 3);
          end else begin
            stall_left = knob_req_stall; rsp_delay = knob_rsp_delay; up_stall_left = knob_up_stall;
          end
        end
      end
      1: begin
        check("timeout_pulse", timeout_pulse, 1'b0);
        check("mem_req_rw", mem_req_rw, cur_rw);
        check("mem_req_addr", mem_req_addr, cur_addr);
        check("mem_req_data", mem_req_data, cur_data);
        if (mem_req_ready) begin phase = 2; age = 0; end
        else stall_left--;
      end
      2: begin
        if (mem_rsp_valid) begin
          check("timeout_pulse", timeout_pulse, 1'b0);
          if (cur_rw) begin
            txn_no++;
            $display("txn %0d: req%0d write addr=%0h absorbed ack after %0d cycles",
                     txn_no, cur_idx, cur_addr, age);
            phase = 0;
          end else begin
            exp_rsp_data = mem_rsp_data; exp_err = 1'b0; phase = 3;
          end
        end else if (age == TO) begin
          check("timeout_pulse", timeout_pulse, 1'b1);
          exp_rsp_data = '0; exp_err = 1'b1; phase = 3;
        end else begin
          check("timeout_pulse", timeout_pulse, 1'b0);
        end
      end
      default: begin
        check("timeout_pulse", timeout_pulse, 1'b0);
        check("up_rsp_data", up_rsp_data, exp_rsp_data);
        check("up_rsp_tag", up_rsp_tag, cur_tag);
        check("up_rsp_err", up_rsp_err, exp_err);
        if (up_rsp_ready[cur_idx]) begin
          txn_no++;
          $display("txn %0d: req%0d %s addr=%0h tag=%0h err=%0d", txn_no, cur_idx,
                   cur_rw ? "write" : "read", cur_addr, cur_tag, exp_err);
          phase = 0;
        end else up_stall_left--;
      end
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_grant(input string tag, input int pos, input int exp_idx);
    int got;
    got = (grant_log.size() > pos) ? grant_log[pos] : -1;
    check(tag, got, exp_idx);
  endtask

  initial begin
    int n0, t0, guard;
    int fair_exp [6] = '{0, 1, 2, 3, 0, 1};

    for (int i = 0; i < N; i++) new_req(i, 1'b0, '0, '0, '0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    apply_reset();

    // Single read with a 20-cycle adapter and a fixed data pattern.
    fixed_data = 1; knob_rsp_delay = 20;
    n0 = obs_rsp_cnt;
    new_req(0, 1'b0, AW'(26'h000010), 8'h5A, rand_line());
    run(30);
    check("single_read_rsp", obs_rsp_cnt - n0, 1);
    fixed_data = 0;

    // Fairness: everyone always requesting, instant memory.
    apply_reset();
    knob_rsp_delay = 1; refill = 1;
    run(40);
    refill = 0;
    run(30);
    for (int k = 0; k < 6; k++) check_grant("fair_order", k, fair_exp[k]);

    // Write absorbed, then the waiting neighbour is served.
    apply_reset();
    knob_rsp_delay = 3;
    n0 = obs_rsp_cnt;
    new_req(2, 1'b1, AW'(26'h0002222), 8'h22, {32{16'h1234}});
    step();
    new_req(3, 1'b0, AW'(26'h0003333), 8'h33, rand_line());
    run(30);
    check_grant("write_first", 0, 2);
    check_grant("write_next", 1, 3);
    check("write_rsp_count", obs_rsp_cnt - n0, 1);

    // Read timeout, then the next requester.
    apply_reset();
    knob_rsp_delay = -1;
    t0 = obs_to_cnt;
    new_req(0, 1'b0, AW'(26'h0000100), 8'h10, rand_line());
    step();
    knob_rsp_delay = 5;
    new_req(1, 1'b0, AW'(26'h0000200), 8'h11, rand_line());
    run(90);
    check("timeout_count", obs_to_cnt - t0, 1);
    check_grant("timeout_first", 0, 0);
    check_grant("timeout_next", 1, 1);

    // Write timeout still produces an error response.
    knob_rsp_delay = -1;
    t0 = obs_to_cnt; n0 = obs_rsp_cnt;
    new_req(2, 1'b1, AW'(26'h0000300), 8'h12, rand_line());
    run(80);
    check("wr_timeout_count", obs_to_cnt - t0, 1);
    check("wr_timeout_rsp", obs_rsp_cnt - n0, 1);

    // Response in the last watchdog cycle wins over the timeout.
    knob_rsp_delay = TO;
    t0 = obs_to_cnt; n0 = obs_rsp_cnt;
    new_req(3, 1'b0, AW'(26'h0000400), 8'h13, rand_line());
    run(80);
    check("tie_no_timeout", obs_to_cnt - t0, 0);
    check("tie_rsp", obs_rsp_cnt - n0, 1);

    // Backpressure on both sides with a competing requester.
    apply_reset();
    knob_req_stall = 5; knob_up_stall = 3; knob_rsp_delay = 4;
    new_req(1, 1'b0, AW'(26'h0000500), 8'h21, rand_line());
    step();
    new_req(2, 1'b0, AW'(26'h0000600), 8'h22, rand_line());
    run(45);
    check_grant("bp_first", 0, 1);
    check_grant("bp_next", 1, 2);
    knob_req_stall = 0; knob_up_stall = 0;

    // Reset ten cycles into WAIT abandons the transaction and restarts at requester 0.
    apply_reset();
    knob_rsp_delay = -1;
    new_req(1, 1'b0, AW'(26'h0000700), 8'h31, rand_line());
    guard = 0;
    while (!(phase == 2 && age >= 10) && guard < 60) begin step(); guard++; end
    check("in_wait", mem_rsp_ready, 1'b1);
    new_req(0, 1'b0, AW'(26'h0000800), 8'h30, rand_line());
    new_req(3, 1'b0, AW'(26'h0000900), 8'h33, rand_line());
    apply_reset();
    knob_rsp_delay = 2;
    n0 = obs_rsp_cnt;
    run(30);
    check_grant("post_reset_first", 0, 0);
    check_grant("post_reset_next", 1, 3);
    check("post_reset_rsp", obs_rsp_cnt - n0, 2);

    // Randomized traffic, then drain.
    apply_reset();
    n0 = obs_rsp_cnt;
    knob_random = 1;
    run(2500);
    knob_random = 0; knob_rsp_delay = 2;
    run(200);
    check("random_activity", obs_rsp_cnt > n0, 1'b1);
    check("drain_idle", {up_req_ready, up_rsp_valid, mem_req_valid, mem_rsp_ready}, '0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_time_limit: got %0t expected under 2ms", $time);
    $fatal(1, "simulation time limit exceeded");
  end

endmodule

// File: doc/vx_ahb_mem_arbiter.md
Name: vx_ahb_mem_arbiter

Overview:
- Shares the single VX-to-AHB memory adapter between NUM_REQS Vortex memory requesters (e.g. I-cache, D-cache, DMA).
- Round-robin arbitration with one transaction in flight, because the adapter is blocking.
- Stores the winner's index and tag, and steers the adapter response back to the winner.
- A watchdog recovers the system if the adapter drops a transaction on an AHB error, because the adapter issues no response in that case.

Parameters:
- NUM_REQS, 4, number of upstream requesters (2..8).
- DATA_WIDTH, 512, Vortex line width.
- ADDR_WIDTH, 26, line address width (32 - log2(DATA_WIDTH/8)).
- TAG_WIDTH, 8, upstream tag width.
- TIMEOUT_CYCLES, 64, watchdog limit from downstream accept to response.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- up_req_valid  in  NUM_REQS  per-requester request valid.
- up_req_rw  in  NUM_REQS  1 = write.
- up_req_addr  in  NUM_REQS*ADDR_WIDTH  line addresses.
- up_req_data  in  NUM_REQS*DATA_WIDTH  write data.
- up_req_tag  in  NUM_REQS*TAG_WIDTH  tags.
- up_req_ready  out  NUM_REQS  one-hot accept.
- up_rsp_valid  out  NUM_REQS  one-hot response valid.
- up_rsp_data  out  DATA_WIDTH  read data, shared by all requesters.
- up_rsp_tag  out  TAG_WIDTH  returned tag.
- up_rsp_err  out  1  response is a timeout error.
- up_rsp_ready  in  NUM_REQS  per-requester response ready.
- mem_req_valid  out  1  request to adapter.
- mem_req_rw  out  1  write flag to adapter.
- mem_req_addr  out  ADDR_WIDTH  address to adapter.
- mem_req_data  out  DATA_WIDTH  write data to adapter.
- mem_req_ready  in  1  adapter accept.
- mem_rsp_valid  in  1  adapter response valid.
- mem_rsp_data  in  DATA_WIDTH  adapter read data.
- mem_rsp_ready  out  1  response accept.
- timeout_pulse  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE; rr_ptr = 0; every output 0.
  - Captured registers and the watchdog counter cleared.
  - Reset mid-transaction abandons it; no response is ever issued for it.
- FSM state IDLE:
  - Grant = first asserted up_req_valid scanning from rr_ptr upward, wrapping.
  - up_req_ready is one-hot for the granted index, combinational, only in IDLE.
  - On handshake: capture idx, rw, addr, data, tag; rr_ptr <= idx+1 (wrapping, NUM_REQS-1 -> 0); go to ISSUE.
- FSM state ISSUE:
  - mem_req_valid = 1 with the captured fields, held stable until mem_req_ready.
  - On accept: clear the watchdog; go to WAIT.
- FSM state WAIT:
  - mem_rsp_ready = 1; the watchdog increments every cycle.
  - mem_rsp_valid with rw = 0: latch mem_rsp_data, err = 0, go to RESP.
  - mem_rsp_valid with rw = 1: the write ack is absorbed and not forwarded; go to IDLE.
  - Watchdog reaches TIMEOUT_CYCLES-1 with no response: timeout_pulse = 1 for one cycle, data = 0, err = 1, go to RESP for reads and writes alike.
  - mem_rsp_valid and timeout in the same cycle: the response wins; no pulse.
- FSM state RESP:
  - up_rsp_valid[idx] = 1; up_rsp_data, up_rsp_tag and up_rsp_err come from registers.
  - Go to IDLE on up_rsp_ready[idx].
  - up_rsp_ready of other indices is ignored.
- Latency:
  - Upstream accept at cycle T gives mem_req_valid at T+1.
  - mem_rsp_valid at cycle R gives up_rsp_valid at R+1.
  - No new grant until the IDLE re-entry cycle, so the minimum gap between grants is 3 cycles plus adapter latency.
- Requesters may deassert up_req_valid before grant without penalty.
- rr_ptr advances only on an actual grant.
- mem_rsp_valid outside WAIT is ignored; mem_rsp_ready is 0 there.

Decomposition:
- Shared package vx_ahb_pkg holds:
  - typedef arb_state_e {IDLE, ISSUE, WAIT, RESP} (2 bits).
  - localparam IDX_WIDTH = $clog2(NUM_REQS).
  - localparam WDOG_WIDTH = $clog2(TIMEOUT_CYCLES).
- Sub-module vx_rr_arbiter, combinational: inputs valid vector and rr_ptr; outputs one-hot grant, grant index and any_valid. Reusable elsewhere.

Test Plan:
- Single read: req0 valid, addr 0x000010, tag 0x5A; adapter responds after 20 cycles with data pattern 0xA5 repeated -> up_rsp_valid[0] one cycle after mem_rsp_valid, tag 0x5A, err 0, data matches.
- Fairness: all 4 requesters hold valid continuously with instant-response memory -> grant order 0,1,2,3,0,1; no requester starved.
- Write absorb: req2 write, data 0x1234... -> mem_req_rw = 1 and data passes through; ack consumed; up_rsp_valid stays 0; next grant goes to req3 if it is waiting.
- Timeout: memory never responds, TIMEOUT_CYCLES = 64 -> timeout_pulse at accept+64, up_rsp_err = 1, data 0, then the arbiter grants the next requester.
- Backpressure: mem_req_ready low for 5 cycles, up_rsp_ready[1] low for 3 cycles -> mem_req fields stable, response held stable, no other grant during either stall.
- Reset mid-WAIT: assert reset 10 cycles into WAIT -> all outputs 0 immediately; after release, rr_ptr = 0 and req0 is granted first.
